// File: rtl/datamem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state,
// port index type and the port count.
package datamem_arb_pkg;

    localparam int NUM_PORTS = 2;

    typedef enum logic {
        ARB  = 1'b0,
        RESP = 1'b1
    } arb_state_t;

    typedef logic port_id_t;

endpackage

// File: rtl/datamem_arbiter_rr_arbiter2.sv
// rr_arbiter2: combinational 2-way round-robin pick.
// In : req_valid[1:0], last_grant. Out: grant one-hot, winner, any_valid.
module rr_arbiter2
    import datamem_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req_valid,
    input  port_id_t             last_grant,
    output logic [NUM_PORTS-1:0] grant,
    output port_id_t             winner,
    output logic                 any_valid
);

    always_comb begin
        winner    = 1'b0;
        any_valid = 1'b1;
        unique case (req_valid)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            // Tie: the port that did not win last time goes now.
            2'b11:   winner = ~last_grant;
            default: any_valid = 1'b0;
        endcase
    end

    assign grant = any_valid ? (2'b01 << winner) : 2'b00;

endmodule

// File: rtl/datamem_arbiter.sv
// datamem_arbiter: shares the word-addressed data memory between the
// LSU (port 0) and the debug/loader port (port 1).
// Ports: clk, rst (sync, active-high); per-port req_valid/req_we/
// req_addr/req_wdata in, req_ready/resp_valid out; shared resp_rdata,
// resp_err; memory side mem_a/mem_wd/mem_we out, mem_rd in.
// Optional DATAMEM_ARB_PERF_EN adds grant_cnt0/1 and conflict_cnt.
module datamem_arbiter
    import datamem_arb_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int unsigned MEM_WORDS  = 32'h00020000
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_PORTS-1:0]                 req_valid,
    input  logic [NUM_PORTS-1:0]                 req_we,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] req_addr,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]                 req_ready,
    output logic [NUM_PORTS-1:0]                 resp_valid,
    output logic [DATA_WIDTH-1:0]                resp_rdata,
    output logic                                 resp_err,
    output logic [DATA_WIDTH-1:0]                mem_a,
    output logic [DATA_WIDTH-1:0]                mem_wd,
    output logic                                 mem_we,
    input  logic [DATA_WIDTH-1:0]                mem_rd
`ifdef DATAMEM_ARB_PERF_EN
    ,
    output logic [31:0]                          grant_cnt0,
    output logic [31:0]                          grant_cnt1,
    output logic [31:0]                          conflict_cnt
`endif
);

    localparam logic [DATA_WIDTH-1:0] MEM_LIMIT = DATA_WIDTH'(MEM_WORDS);

    arb_state_t           state;
    port_id_t             last_grant;
    port_id_t             owner;
    port_id_t             win;
    logic [NUM_PORTS-1:0] gnt;
    logic                 any_valid;
    logic                 accept;
    logic [DATA_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                 sel_we;
    logic                 in_range;

    rr_arbiter2 u_rr (
        .req_valid  (req_valid),
        .last_grant (last_grant),
        .grant      (gnt),
        .winner     (win),
        .any_valid  (any_valid)
    );

    assign sel_addr  = req_addr[win];
    assign sel_wdata = req_wdata[win];
    assign sel_we    = req_we[win];
    assign in_range  = sel_addr < MEM_LIMIT;

    // Reset overrides everything combinational: no grant, no write.
    assign accept = (state == ARB) && !rst && any_valid;

    always_comb begin
        req_ready = '0;
        mem_a     = '0;
        mem_wd    = '0;
        mem_we    = 1'b0;
        if (accept) begin
            req_ready = gnt;
            mem_a     = sel_addr;
            mem_wd    = sel_wdata;
            mem_we    = sel_we && in_range;
        end
    end

    // Pulse is derived from state so a reset in RESP can squash it.
    always_comb begin
        resp_valid = '0;
        if ((state == RESP) && !rst)
            resp_valid[owner] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            unique case (state)
                ARB: begin
                    if (any_valid) begin
                        // Writes and out-of-range accesses return zero data.
                        resp_rdata <= (in_range && !sel_we) ? mem_rd : '0;
                        resp_err   <= !in_range;
                        owner      <= win;
                        last_grant <= win;
                        state      <= RESP;
                    end
                end
                RESP: state <= ARB;
                default: state <= ARB;
            endcase
        end
    end

`ifdef DATAMEM_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt0   <= '0;
            grant_cnt1   <= '0;
            conflict_cnt <= '0;
        end else if (state == ARB) begin
            if (req_valid == 2'b11)
                conflict_cnt <= conflict_cnt + 32'd1;
            if (any_valid && !win)
                grant_cnt0 <= grant_cnt0 + 32'd1;
            if (any_valid && win)
                grant_cnt1 <= grant_cnt1 + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_datamem_arbiter.sv
// Directed self-checking bench for datamem_arbiter with a small
// behavioural memory indexed by mem_a[7:0].
module tb_datamem_arbiter;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       req_valid = '0;
    logic [1:0]       req_we = '0;
    logic [1:0][31:0] req_addr = '0;
    logic [1:0][31:0] req_wdata = '0;
    logic [1:0]       req_ready;
    logic [1:0]       resp_valid;
    logic [31:0]      resp_rdata;
    logic             resp_err;
    logic [31:0]      mem_a;
    logic [31:0]      mem_wd;
    logic             mem_we;
    logic [31:0]      mem_rd;
`ifdef DATAMEM_ARB_PERF_EN
    logic [31:0]      grant_cnt0;
    logic [31:0]      grant_cnt1;
    logic [31:0]      conflict_cnt;
`endif

    logic [31:0] mem [256];
    logic        mem_init = 1'b1;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    datamem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_we     (mem_we),
        .mem_rd     (mem_rd)
`ifdef DATAMEM_ARB_PERF_EN
        ,
        .grant_cnt0   (grant_cnt0),
        .grant_cnt1   (grant_cnt1),
        .conflict_cnt (conflict_cnt)
`endif
    );

    assign mem_rd = mem[mem_a[7:0]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++)
                mem[i] <= '0;
            mem[0] <= 32'hDEADBEEF;
        end else if (mem_we) begin
            mem[mem_a[7:0]] <= mem_wd;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 2'b11;
        repeat (2) begin
            @(negedge clk);
            chk("rst_ready", 32'(req_ready), 32'd0);
            chk("rst_mem_we", 32'(mem_we), 32'd0);
            chk("rst_mem_a", mem_a, 32'd0);
            step();
        end
        rst = 1'b0;
        req_valid = 2'b00;
        @(negedge clk);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
        step();
    endtask

    task automatic do_req(input int p, input logic we,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err);
        logic [1:0] one;
        int n;
        one = 2'b01 << p;
        n = 0;
        req_valid[p] = 1'b1;
        req_we[p]    = we;
        req_addr[p]  = a;
        req_wdata[p] = wd;
        @(negedge clk);
        while (!req_ready[p] && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready", 32'(req_ready), 32'(one));
        chk("mem_a", mem_a, a);
        chk("mem_we", 32'(mem_we), 32'(we && !exp_err));
        step();
        req_valid[p] = 1'b0;
        @(negedge clk);
        chk("resp_valid", 32'(resp_valid), 32'(one));
        chk("resp_rdata", resp_rdata, exp_rd);
        chk("resp_err", 32'(resp_err), 32'(exp_err));
        chk("resp_mem_we", 32'(mem_we), 32'd0);
        step();
    endtask

    initial begin
        logic [1:0] exp_rdy;
        logic [1:0] prev;

        step();
        mem_init = 1'b0;
        do_reset();

        // Single read on port 0.
        do_req(0, 1'b0, 32'h10000, 32'h0, 32'hDEADBEEF, 1'b0);

        // Write then read back on port 1.
        do_req(1, 1'b1, 32'h10004, 32'hCAFEF00D, 32'h0, 1'b0);
        chk("mem_10004", mem[4], 32'hCAFEF00D);
        do_req(1, 1'b0, 32'h10004, 32'h0, 32'hCAFEF00D, 1'b0);

        // Out-of-range write: no write, error flag, zero data.
        do_req(0, 1'b1, 32'h00020000, 32'h12345678, 32'h0, 1'b1);
        chk("oor_mem_unchanged", mem[0], 32'hDEADBEEF);

        // Pointer still advanced past port 0: tie now goes to port 1.
        req_addr[0] = 32'h10000;
        req_addr[1] = 32'h10004;
        req_we = 2'b00;
        req_valid = 2'b11;
        @(negedge clk);
        chk("rr_after_oor", 32'(req_ready), 32'h2);
        step();
        req_valid = 2'b00;
        @(negedge clk);
        chk("rr_after_oor_resp", 32'(resp_valid), 32'h2);
        chk("rr_after_oor_data", resp_rdata, 32'hCAFEF00D);
        step();

        // Contention: both ports hold reads for 8 cycles after reset.
        do_reset();
        req_valid = 2'b11;
        prev = 2'b00;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k % 2 == 0) begin
                exp_rdy = ((k / 2) % 2 == 0) ? 2'b01 : 2'b10;
                chk("cont_ready", 32'(req_ready), 32'(exp_rdy));
                chk("cont_resp_idle", 32'(resp_valid), 32'd0);
                prev = exp_rdy;
            end else begin
                chk("cont_ready_resp", 32'(req_ready), 32'd0);
                chk("cont_resp", 32'(resp_valid), 32'(prev));
                chk("cont_data", resp_rdata,
                    (prev == 2'b01) ? 32'hDEADBEEF : 32'hCAFEF00D);
            end
            step();
        end
        req_valid = 2'b00;

        // Reset in the RESP cycle squashes the pulse and the pointer.
        req_valid = 2'b01;
        @(negedge clk);
        chk("mid_ready", 32'(req_ready), 32'h1);
        step();
        rst = 1'b1;
        req_valid = 2'b11;
        @(negedge clk);
        chk("mid_resp_squash", 32'(resp_valid), 32'd0);
        chk("mid_rst_wins", 32'(req_ready), 32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rdata_rst", resp_rdata, 32'd0);
        chk("mid_err_rst", 32'(resp_err), 32'd0);
        chk("mid_resp_rst", 32'(resp_valid), 32'd0);
        chk("mid_tie_p0", 32'(req_ready), 32'h1);
        step();
        req_valid = 2'b00;
        @(negedge clk);
        chk("mid_after_resp", 32'(resp_valid), 32'h1);
        chk("mid_after_data", resp_rdata, 32'hDEADBEEF);
        step();

`ifdef DATAMEM_ARB_PERF_EN
        // 10 contended cycles = 5 grants (0,1,0,1,0), then 3 port-0 reads.
        do_reset();
        req_valid = 2'b11;
        repeat (10) step();
        req_valid = 2'b00;
        repeat (3) do_req(0, 1'b0, 32'h10000, 32'h0, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        chk("grant_cnt0", grant_cnt0, 32'd6);
        chk("grant_cnt1", grant_cnt1, 32'd2);
        chk("conflict_cnt", conflict_cnt, 32'd5);
        step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/datamem_arbiter.md
Name: datamem_arbiter

Overview:
- Shares the single-port, word-addressed data memory between two requesters: port 0 (CPU load/store unit) and port 1 (debug/loader port).
- Each port has a valid/ready request channel and a response pulse.
- Sits between the requesters and the data memory, and drives the memory's address, write-data and write-enable.
- Memory read data is combinational from address; the arbiter registers it into the response.

Parameters:
- DATA_WIDTH, 32, width of data and address buses.
- MEM_WORDS, 32'h00020000, number of valid memory words; addresses at or above this are out of range.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  2  per-port request valid; bit i belongs to port i.
- req_we  input  2  per-port write (1) / read (0).
- req_addr  input  2xDATA_WIDTH  per-port word address.
- req_wdata  input  2xDATA_WIDTH  per-port write data.
- req_ready  output  2  per-port request accepted this cycle.
- resp_valid  output  2  per-port one-cycle response pulse.
- resp_rdata  output  DATA_WIDTH  read data; meaningful when any resp_valid bit is high.
- resp_err  output  1  address-range error flag, qualified by resp_valid.
- mem_a  output  DATA_WIDTH  memory address.
- mem_wd  output  DATA_WIDTH  memory write data.
- mem_we  output  1  memory write enable.
- mem_rd  input  DATA_WIDTH  memory read data, combinational from mem_a.

Behaviour:
- One clock domain; reset is synchronous and active-high on clk/rst. All state updates on rising clk.
- FSM states are ARB and RESP. Reset enters ARB.
- Reset values:
  - req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0.
  - mem_we=0; mem_a and mem_wd driven 0.
  - Round-robin pointer last_grant=1, so port 0 wins the first tie.
- ARB state:
  - Winner selection:
    - Only one port valid: that port wins.
    - Both valid: the port not equal to last_grant wins.
    - None valid: stay in ARB; all outputs idle.
  - With a winner w, combinationally:
    - req_ready[w]=1; the other req_ready bit is 0.
    - mem_a=req_addr[w] and mem_wd=req_wdata[w].
    - mem_we=req_we[w] AND in_range, where in_range = (req_addr[w] < MEM_WORDS).
  - On that clock edge:
    - Capture resp_rdata = in_range ? mem_rd : 0.
    - Capture resp_err = !in_range and owner = w.
    - last_grant <= w; next state RESP.
- RESP state:
  - resp_valid[owner]=1 for exactly this cycle; req_ready=0; mem_we=0.
  - Next state is ARB.
  - Writes also get a response pulse (acknowledge); for writes resp_rdata=0.
- Latency and throughput:
  - Request accepted in cycle N; response valid in cycle N+1.
  - Maximum throughput is one access per 2 cycles.
  - Under continuous dual requests, grants alternate 0,1,0,1.
- Requester rule: hold req_valid, req_we, req_addr and req_wdata stable until req_ready is seen. The arbiter never drops a held request.
- Out-of-range access:
  - No memory write.
  - resp_err=1 and resp_rdata=0.
  - The round-robin pointer still advances.
- Reset mid-operation: rst in RESP suppresses the pending response pulse; the FSM returns to ARB with reset values. Any write already performed in the ARB cycle stays committed.
- Simultaneous rst and req_valid: rst wins; nothing is accepted that cycle.

Optional Feature:
- Macro DATAMEM_ARB_PERF_EN.
- Defined:
  - Adds outputs grant_cnt0 and grant_cnt1, each 32 bits, counting accepted requests per port.
  - Adds output conflict_cnt, 32 bits, counting ARB cycles where both ports were valid.
  - All counters wrap modulo 2^32 and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package datamem_arb_pkg holds:
  - typedef arb_state_t {ARB, RESP};
  - typedef port_id_t (1 bit);
  - localparam NUM_PORTS=2.
- One sub-module, rr_arbiter2: combinational 2-way round-robin winner from req_valid and last_grant. It outputs the grant one-hot and the winner index.

Test Plan:
- Single read, port 0: mem word 0x10000=0xDEADBEEF; port0 reads 0x10000 → req_ready[0] in cycle N; resp_valid[0] in N+1 with resp_rdata=0xDEADBEEF, resp_err=0.
- Write then read, port 1: port1 writes 0xCAFEF00D to 0x10004 → mem_we=1 for exactly one cycle, ack pulse on resp_valid[1]; a following read of 0x10004 returns 0xCAFEF00D.
- Contention: both ports hold reads for 8 cycles after reset → grants in order 0,1,0,1 on alternate ARB cycles; no resp_valid on the non-owner port.
- Out of range: port0 writes 0x00020000 → mem_we stays 0, resp_err=1, resp_rdata=0; the memory location is unchanged.
- Reset mid-operation: assert rst in the RESP cycle → no resp_valid that cycle; next cycle all outputs are at reset values and a tie grants port 0.
- DATAMEM_ARB_PERF_EN: 5 contended accesses and 3 single port-0 accesses → grant_cnt0=6, grant_cnt1=2, conflict_cnt=5 (or as computed from the exact schedule).
